// File: rtl/row_token_arbiter.sv
// row_token_arbiter
//   Frame-based row-readout arbiter for the pixel-array column logic. A Start
//   pulse snapshots the per-row token lines. Pending rows are then offered one
//   at a time on a valid/ready interface as a binary row address. The order is
//   either fixed priority (lowest index first) or round-robin (the search
//   origin rotates from frame to frame). Each accepted row receives a one-cycle
//   one-hot Ack. Done pulses once the frame has drained.
//
// Ports
//   Clk       rising-edge clock
//   Rst_b     asynchronous reset, active low
//   Token     [NROWS] per-row "has data" levels, sampled only at Start
//   Start     one-cycle frame start, honoured only when idle
//   Abort     drops the current frame (no Ack/Done for a coincident handshake)
//   RowValid  RowAddr holds a pending row
//   RowAddr   [AW] binary index of the offered row
//   RowReady  consumer accepts the offered row
//   Ack       [NROWS] one-hot pulse for the row accepted on the previous cycle
//   Done      one-cycle pulse at frame completion
//   Busy      high whenever the arbiter is not idle
module row_token_arbiter #(
  parameter int NROWS       = 16,
  parameter int AW          = $clog2(NROWS),
  parameter int ROUND_ROBIN = 0
) (
  input  logic             Clk,
  input  logic             Rst_b,
  input  logic [NROWS-1:0] Token,
  input  logic             Start,
  input  logic             Abort,
  output logic             RowValid,
  output logic [AW-1:0]    RowAddr,
  input  logic             RowReady,
  output logic [NROWS-1:0] Ack,
  output logic             Done,
  output logic             Busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [NROWS-1:0] pending_q,   pending_d;
  logic             row_valid_q, row_valid_d;
  logic [AW-1:0]    row_addr_q,  row_addr_d;
  logic [NROWS-1:0] ack_q,       ack_d;
  logic             done_q,      done_d;
  logic             busy_q,      busy_d;
  logic [AW-1:0]    rr_ptr_q,    rr_ptr_d;

  logic             handshake_s;
  logic [NROWS-1:0] row_onehot_s;
  logic [NROWS-1:0] pend_left_s;
  logic [AW-1:0]    search_base_s;
  logic [AW-1:0]    rr_next_s;

  // First set bit of pend, scanning upward from base and wrapping modulo NROWS.
  function automatic logic [AW-1:0] select_row(input logic [NROWS-1:0] pend,
                                               input logic [AW-1:0]    base);
    logic          found;
    logic [AW-1:0] sel;
    int            idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NROWS; k++) begin
      idx = int'(base) + k;
      idx = (idx >= NROWS) ? (idx - NROWS) : idx;
      if (!found && pend[AW'(idx)]) begin
        found = 1'b1;
        sel   = AW'(idx);
      end
    end
    return sel;
  endfunction

  // Handshake decode, remaining-row mask and search origin for the next pick.
  always_comb begin
    handshake_s   = row_valid_q & RowReady;
    row_onehot_s  = {{(NROWS-1){1'b0}}, 1'b1} << row_addr_q;
    pend_left_s   = pending_q & ~row_onehot_s;
    // The origin stays fixed for the whole frame; it only moves between frames.
    search_base_s = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;
    rr_next_s     = (row_addr_q == AW'(NROWS-1)) ? '0 : (row_addr_q + AW'(1));
  end

  // Next-state logic for the frame FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    row_valid_d = row_valid_q;
    row_addr_d  = row_addr_q;
    ack_d       = '0;
    done_d      = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (Abort) begin
      state_d     = S_IDLE;
      pending_d   = '0;
      row_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            pending_d = Token;
            if (Token == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d     = S_SERVE;
              row_valid_d = 1'b1;
              row_addr_d  = select_row(Token, search_base_s);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SERVE: begin
          if (handshake_s) begin
            pending_d = pend_left_s;
            ack_d     = row_onehot_s;
            if (pend_left_s == '0) begin
              state_d     = S_DONE;
              row_valid_d = 1'b0;
              done_d      = 1'b1;
              rr_ptr_d    = rr_next_s;
            end else begin
              // Register the next pick now so the following cycle has no bubble.
              row_addr_d = select_row(pend_left_s, search_base_s);
            end
          end else begin
            state_d = S_SERVE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d     = S_IDLE;
          pending_d   = '0;
          row_valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst_b) begin
    if (!Rst_b) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      row_valid_q <= 1'b0;
      row_addr_q  <= '0;
      ack_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      row_valid_q <= row_valid_d;
      row_addr_q  <= row_addr_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign RowValid = row_valid_q;
  assign RowAddr  = row_addr_q;
  assign Ack      = ack_q;
  assign Done     = done_q;
  assign Busy     = busy_q;

endmodule

// File: doc/row_token_arbiter.md
# row_token_arbiter

Sequential, parametrised row-readout arbiter for the pixel-array column logic. On a Start pulse it snapshots NROWS token lines. It then serves the pending rows one per valid/ready handshake, presenting a binary row address, in either fixed-priority or round-robin order. It pulses a one-hot Ack back to each served row and signals Done when the frame is drained. It sits between the per-row token chain and the column readout FIFO, and replaces the fixed 16-row combinational address decoder.

## Interface
- NROWS, 16: number of token lines; any value from 2 to 256.
- AW, $clog2(NROWS): width of the row address.
- ROUND_ROBIN, 0: 0 = fixed priority, lowest index first; 1 = rotating start index across frames.

Ports:
- Clk  in  1  the single clock; all state is updated on its rising edge.
- Rst_b  in  1  asynchronous reset, active low; release is synchronised externally.
- Token  in  NROWS  level; bit i=1 means row i has data. Sampled only at Start.
- Start  in  1  one-cycle frame start; honoured only in IDLE.
- Abort  in  1  drops the frame; highest priority after reset.
- RowValid  out  1  RowAddr holds a valid pending row.
- RowAddr  out  AW  binary index of the row being offered.
- RowReady  in  1  the consumer accepts the offered row.
- Ack  out  NROWS  one-hot, one-cycle pulse for the row accepted on the previous cycle.
- Done  out  1  one-cycle pulse when the frame is complete.
- Busy  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, SERVE and DONE. Reset value: IDLE, pending=0, RowValid=0, RowAddr=0, Ack=0, Done=0, Busy=0, rr_ptr=0.
- IDLE with Start:
  - pending <= Token.
  - If Token==0, go to DONE.
  - Otherwise go to SERVE. RowAddr is loaded with the first selected index and RowValid is set.
- SERVE:
  - RowValid=1 and RowAddr are stable until RowValid&RowReady. No output may change while the consumer stalls.
  - On a handshake, pending bit RowAddr is cleared. The next selection is computed from pending with that bit removed and registered, so throughput is one row per cycle with no bubbles.
  - On the handshake that clears the last pending bit, go to DONE and drop RowValid.
- DONE lasts one cycle: Done=1, then IDLE.
- Selection rule, ROUND_ROBIN=0: lowest set index in pending.
- Selection rule, ROUND_ROBIN=1:
  - Search starts at rr_ptr and wraps modulo NROWS; the first set bit wins.
  - rr_ptr is loaded with (last served index + 1) mod NROWS at the end of each frame.
  - rr_ptr is unchanged by an empty frame or an Abort.
- Abort in any state: pending<=0, RowValid<=0, state<=IDLE on the next edge. No Done and no Ack are issued for a handshake coinciding with Abort. Abort with Start in IDLE: Abort wins.
- Start outside IDLE is ignored.
- Token changes after the snapshot do not affect the current frame.
- Ack never has more than one bit set.
- Every row set in the snapshot is acked exactly once per frame unless the frame is aborted.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately. rr_ptr=0.

## Timing
- Start accepted at edge t: RowValid=1 with the first RowAddr after edge t+1. Empty Token: Done=1 after edge t+1, Busy=0 after edge t+2.
- Handshake sampled at edge c:
  - Ack[RowAddr] high for the cycle after c.
  - The next RowAddr is valid after c, or RowValid=0 and Done=1 if that was the last row.
- Back-to-back: RowReady held high drains K pending rows in K cycles. Done follows one cycle after the last handshake.
- Busy=1 from the edge after Start through the Done cycle inclusive. The next Start is accepted the cycle after Done.

## Test plan
- Fixed priority (NROWS=16, ROUND_ROBIN=0): Token=16'h8421, Start, RowReady=1 -> RowAddr sequence 0,5,10,15 on consecutive cycles. Ack=0x0001,0x0020,0x0400,0x8000 each lag by one cycle. Done follows the last Ack.
- Backpressure: Token=16'h0006, RowReady low for 5 cycles -> RowAddr=1 stays stable with RowValid=1 and no Ack. Releasing RowReady serves 1 then 2.
- Empty and snapshot: Start with Token=0 -> Done on the next cycle with RowValid never high. Start with Token=16'h0001, then Token changed to 16'hFFFF -> only row 0 is served.
- Round-robin (ROUND_ROBIN=1):
  - Frame 1, Token=16'h0011 -> order 0,4; rr_ptr becomes 5.
  - Frame 2, Token=16'h0031 -> order 5,0,4; rr_ptr becomes 5.
  - Frame 3, Token=16'h8001 -> order 15,0.
- Abort and reset: Token=16'h00FF, abort after 3 handshakes coincident with the 4th -> no Ack for row 3 and no Done; the next Start behaves as fresh. Separately, Rst_b low mid-frame -> all outputs 0 asynchronously and rr_ptr=0.
- Width corner: NROWS=5, AW=3, ROUND_ROBIN=1, Token=5'b10001 over repeated frames -> wrap from index 4 to 0. RowAddr never exceeds 4.
